cpu_interrupt_sequencer: RTL and testbench
==========================================

Name: cpu_interrupt_sequencer

Overview:
- Consumer stage for the NMI falling-edge detector. Takes the latched `nmi_pending` flag, the level-sensitive IRQ line, BRK decode and reset.
- Arbitrates them at instruction boundaries and runs the 7-cycle 6502 interrupt entry sequence. It drives stack-push strobes, vector-fetch strobes and the vector address to the CPU core.
- Returns a one-cycle `nmi_clear` pulse to the edge detector's `clear` input once the NMI vector is committed.

Parameters:
- VEC_NMI, 16'hFFFA, NMI vector low-byte address
- VEC_RESET, 16'hFFFC, RESET vector low-byte address
- VEC_IRQ, 16'hFFFE, IRQ/BRK vector low-byte address

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ce  in  1  CPU cycle enable; all state advances only when ce=1
- sync  in  1  opcode-fetch cycle (instruction boundary) from the core
- brk_op  in  1  opcode latched on this sync is BRK (valid with sync)
- nmi_pending  in  1  latched NMI edge from the falling edge detector
- irq_n  in  1  active-low level IRQ
- i_flag  in  1  processor status I bit
- busy  out  1  sequence in progress; core suppresses normal execution
- seq_cycle  out  3  current sequence cycle 0..6 (0 when idle)
- stack_push  out  1  push strobe (cycles 2,3,4)
- push_sel  out  2  00=PCH, 01=PCL, 10=P
- push_b  out  1  B bit value for pushed P (1 only for BRK)
- vec_fetch_lo  out  1  read vector low byte (cycle 5)
- vec_fetch_hi  out  1  read vector high byte (cycle 6)
- vector_addr  out  16  address of the current vector fetch
- set_i  out  1  set I flag (cycle 5 pulse)
- nmi_clear  out  1  one-ce-cycle pulse to edge detector clear

Behaviour:
- States: IDLE, SEQ.
- Internal source register `src`: RESET, NMI, IRQ, BRK.
- Reset (rst_n=0, asynchronous):
  - state=SEQ, src=RESET, seq_cycle=0.
  - All strobes=0, nmi_clear=0, push_b=0, vector_addr=VEC_RESET, busy=1.
  - After release, the reset sequence runs on ce cycles.
- Entry from IDLE (on ce & sync):
  - Priority: nmi_pending > (!irq_n & !i_flag) > brk_op.
  - Winner → SEQ, seq_cycle=0 on the next ce cycle. busy rises on that cycle.
  - No winner → stay IDLE.
- SEQ advances seq_cycle by 1 per ce cycle.
  - Cycles 0-1: dummy reads, no strobes.
  - Cycles 2/3/4: stack_push=1 with push_sel PCH/PCL/P, except src=RESET, where stack_push stays 0 (reads only) but the cycle still elapses.
  - push_b=1 only during cycle 4 with src=BRK.
  - Cycle 5: vec_fetch_lo=1, vector_addr=vector base, set_i=1.
  - Cycle 6: vec_fetch_hi=1, vector_addr=base+1.
  - At end of cycle 6 → IDLE, busy=0, seq_cycle=0.
  - Total latency from the winning sync to vec_fetch_hi is 7 ce cycles.
- nmi_clear:
  - Asserted for exactly one ce cycle, coincident with cycle 5, when the committed source is NMI.
  - Never asserted for RESET/IRQ/BRK.
- IRQ is level-sampled only at sync. Deassertion after entry does not abort the sequence.
- nmi_pending rising while idle and not at sync is held by the edge detector and is taken at the next sync.
- nmi_pending during SEQ at cycles 5-6, or on the last-sequence sync: not serviced until the next instruction boundary. nmi_pending remains set because nmi_clear was not pulsed.
- Simultaneous NMI and IRQ at sync: NMI wins. IRQ remains level and is taken at a later sync if still asserted and I=0. i_flag is then 1 from set_i.
- ce=0: all registers hold. Strobes are qualified by ce (strobe outputs = state decode AND ce).
- Reset asserted mid-sequence: immediate abort to the reset state above. No nmi_clear is issued.

Optional Feature:
- Macro: NMI_HIJACK_EN.
- Defined: if src is IRQ or BRK and nmi_pending=1 on a ce cycle during seq_cycle 0-4, then src becomes NMI (BRK keeps push_b=1 if the switch happens after cycle 4 push; otherwise push_b follows BRK). Vector fetch uses VEC_NMI and nmi_clear pulses at cycle 5. This matches 6502 hijack.
- Undefined: src is fixed at entry. The NMI waits for the next sync.

Test Plan:
- Release rst_n with ce=1 → 7 cycles: no stack_push, vec_fetch_lo at vector_addr=FFFC then vec_fetch_hi at FFFD, busy falls, nmi_clear never high.
- nmi_pending=1, pulse sync → cycles 2-4 push PCH/PCL/P with push_b=0, cycle 5 addr FFFA with set_i=1 and nmi_clear=1 for one cycle, cycle 6 addr FFFB.
- irq_n=0 with i_flag=1 at sync → stays IDLE. With i_flag=0 → sequence with vector FFFE/FFFF.
- sync with brk_op=1 and irq_n=1 → vector FFFE, push_b=1 only at cycle 4.
- nmi_pending and irq_n=0 at the same sync → NMI vector FFFA. Toggle ce 1-of-3 during the sequence → cycle count measured in ce cycles is still 7.
- IRQ sequence, raise nmi_pending at seq_cycle 2 → with NMI_HIJACK_EN: vector FFFA plus nmi_clear; without: vector FFFE and nmi_pending still high at exit. Assert rst_n=0 at cycle 3 → immediate busy=1, seq_cycle=0, vector_addr=FFFC.

Source files
------------

// File: rtl/cpu_interrupt_sequencer.sv
// cpu_interrupt_sequencer: arbitrates RESET/NMI/IRQ/BRK at instruction
// boundaries and runs the 7-cycle 6502 interrupt entry sequence. The sequence
// pushes PCH/PCL/P, fetches the vector and pulses nmi_clear back to the NMI
// edge detector once the NMI vector is committed.
// Optional build macro NMI_HIJACK_EN: an NMI arriving during cycles 0-4 of an
// IRQ/BRK sequence redirects the vector fetch to the NMI vector.
module cpu_interrupt_sequencer #(
  parameter logic [15:0] VEC_NMI   = 16'hFFFA,
  parameter logic [15:0] VEC_RESET = 16'hFFFC,
  parameter logic [15:0] VEC_IRQ   = 16'hFFFE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ce,
  input  logic        sync,
  input  logic        brk_op,
  input  logic        nmi_pending,
  input  logic        irq_n,
  input  logic        i_flag,
  output logic        busy,
  output logic [2:0]  seq_cycle,
  output logic        stack_push,
  output logic [1:0]  push_sel,
  output logic        push_b,
  output logic        vec_fetch_lo,
  output logic        vec_fetch_hi,
  output logic [15:0] vector_addr,
  output logic        set_i,
  output logic        nmi_clear
);

  typedef enum logic {IDLE, SEQ} state_t;
  typedef enum logic [1:0] {SRC_RESET, SRC_NMI, SRC_IRQ, SRC_BRK} src_t;

  localparam logic [2:0] LAST_CYCLE = 3'd6;

  state_t     state_q, state_d;
  src_t       src_q, src_d;
  logic [2:0] cyc_q, cyc_d;
  // Remembers that the sequence was entered by BRK so the pushed B bit
  // survives a later switch of the vector source.
  logic       brk_q, brk_d;

  // State register: reset forces the RESET sequence to start immediately.
  // NOTE: sequential state uses non-blocking assignments only; blocking here
  // would make the result depend on process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEQ;
      src_q   <= SRC_RESET;
      cyc_q   <= 3'd0;
      brk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      cyc_q   <= cyc_d;
      brk_q   <= brk_d;
    end
  end

  // Next-state: arbitration at sync while idle, cycle counting while in SEQ.
  // NOTE: every variable gets its hold value first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    cyc_d   = cyc_q;
    brk_d   = brk_q;
    if (ce) begin
      case (state_q)
        IDLE: begin
          if (sync) begin
            cyc_d = 3'd0;
            if (nmi_pending) begin
              state_d = SEQ;
              src_d   = SRC_NMI;
              brk_d   = 1'b0;
            end else if (!irq_n && !i_flag) begin
              state_d = SEQ;
              src_d   = SRC_IRQ;
              brk_d   = 1'b0;
            end else if (brk_op) begin
              state_d = SEQ;
              src_d   = SRC_BRK;
              brk_d   = 1'b1;
            end
          end
        end
        SEQ: begin
          if (cyc_q == LAST_CYCLE) begin
            state_d = IDLE;
            cyc_d   = 3'd0;
          end else begin
            cyc_d = cyc_q + 3'd1;
          end
`ifdef NMI_HIJACK_EN
          // Late NMI steals the vector of an IRQ/BRK still before its fetch.
          if (nmi_pending && (cyc_q <= 3'd4) &&
              ((src_q == SRC_IRQ) || (src_q == SRC_BRK))) begin
            src_d = SRC_NMI;
          end
`endif
        end
        default: state_d = IDLE;
      endcase
    end
  end

  logic        in_seq;
  logic        push_cyc;
  logic [15:0] vec_base;

  // Output decode: strobes are the state decode qualified by ce.
  always_comb begin
    in_seq    = (state_q == SEQ);
    busy      = in_seq;
    seq_cycle = cyc_q;

    case (src_q)
      SRC_NMI:   vec_base = VEC_NMI;
      SRC_RESET: vec_base = VEC_RESET;
      default:   vec_base = VEC_IRQ;
    endcase
    vector_addr = (in_seq && cyc_q == LAST_CYCLE) ? 16'(vec_base + 16'd1) : vec_base;

    // RESET lets the push cycles elapse as reads only.
    push_cyc   = in_seq && (cyc_q >= 3'd2) && (cyc_q <= 3'd4) && (src_q != SRC_RESET);
    stack_push = ce && push_cyc;
    case (cyc_q)
      3'd3:    push_sel = 2'b01;
      3'd4:    push_sel = 2'b10;
      default: push_sel = 2'b00;
    endcase
    push_b = ce && push_cyc && (cyc_q == 3'd4) && brk_q;

    vec_fetch_lo = ce && in_seq && (cyc_q == 3'd5);
    set_i        = vec_fetch_lo;
    vec_fetch_hi = ce && in_seq && (cyc_q == LAST_CYCLE);
    nmi_clear    = vec_fetch_lo && (src_q == SRC_NMI);
  end

endmodule

// File: tb/tb_cpu_interrupt_sequencer.sv
// Testbench for cpu_interrupt_sequencer: directed stimulus pushes the expected
// sequence summary into a queue; a monitor assembles each observed sequence
// and compares it when the high vector byte is fetched.
`timescale 1ns/1ps
module tb_cpu_interrupt_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ce = 1'b1;
  logic        sync = 1'b0;
  logic        brk_op = 1'b0;
  logic        nmi_pending;
  logic        irq_n = 1'b1;
  logic        i_flag = 1'b1;
  logic        busy;
  logic [2:0]  seq_cycle;
  logic        stack_push;
  logic [1:0]  push_sel;
  logic        push_b;
  logic        vec_fetch_lo;
  logic        vec_fetch_hi;
  logic [15:0] vector_addr;
  logic        set_i;
  logic        nmi_clear;

  logic nmi_fall = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  typedef struct packed {
    logic [15:0] lo;
    logic [6:0]  push_m;
    logic [6:0]  pb_m;
    logic [6:0]  clr_m;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  cpu_interrupt_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ce           (ce),
    .sync         (sync),
    .brk_op       (brk_op),
    .nmi_pending  (nmi_pending),
    .irq_n        (irq_n),
    .i_flag       (i_flag),
    .busy         (busy),
    .seq_cycle    (seq_cycle),
    .stack_push   (stack_push),
    .push_sel     (push_sel),
    .push_b       (push_b),
    .vec_fetch_lo (vec_fetch_lo),
    .vec_fetch_hi (vec_fetch_hi),
    .vector_addr  (vector_addr),
    .set_i        (set_i),
    .nmi_clear    (nmi_clear)
  );

  // Model of the NMI edge detector: set by a falling edge, cleared by nmi_clear.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)         nmi_pending <= 1'b0;
    else if (nmi_fall)  nmi_pending <= 1'b1;
    else if (nmi_clear) nmi_pending <= 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [15:0] lo, input bit pushes, input bit brk, input bit clr);
    exp_t e;
    e.lo     = lo;
    e.push_m = pushes ? 7'b0011100 : 7'b0000000;
    e.pb_m   = brk    ? 7'b0010000 : 7'b0000000;
    e.clr_m  = clr    ? 7'b0100000 : 7'b0000000;
    return e;
  endfunction

  // Monitor: accumulate per-cycle strobe masks, compare at vec_fetch_hi.
  int          idx;
  logic [6:0]  push_m, pb_m, clr_m, seti_m, lo_m;
  logic [5:0]  sels;
  logic [15:0] lo_a;
  exp_t        e;

  always @(negedge clk) begin
    if (!rst_n || !busy) begin
      idx = 0; push_m = '0; pb_m = '0; clr_m = '0; seti_m = '0; lo_m = '0;
      sels = '0; lo_a = '0;
      check("idle_strobes", {26'd0, stack_push, push_b, vec_fetch_lo, vec_fetch_hi, set_i, nmi_clear}, 32'd0);
    end else if (!ce) begin
      check("ce0_strobes", {26'd0, stack_push, push_b, vec_fetch_lo, vec_fetch_hi, set_i, nmi_clear}, 32'd0);
    end else begin
      check("seq_cycle", {29'd0, seq_cycle}, idx);
      if (idx < 7) begin
        if (stack_push) begin
          push_m[idx] = 1'b1;
          sels = {sels[3:0], push_sel};
        end
        if (push_b)       pb_m[idx]   = 1'b1;
        if (nmi_clear)    clr_m[idx]  = 1'b1;
        if (set_i)        seti_m[idx] = 1'b1;
        if (vec_fetch_lo) begin
          lo_m[idx] = 1'b1;
          lo_a      = vector_addr;
        end
      end
      if (vec_fetch_hi) begin
        if (exp_q.size() == 0) begin
          check("unexpected_seq", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("vec_lo_addr", {16'd0, lo_a}, {16'd0, e.lo});
          check("vec_hi_addr", {16'd0, vector_addr}, {16'd0, 16'(e.lo + 16'd1)});
          check("hi_cycle", idx, 32'd6);
          check("lo_cycle", {25'd0, lo_m}, 32'b0100000);
          check("set_i_cycle", {25'd0, seti_m}, 32'b0100000);
          check("push_mask", {25'd0, push_m}, {25'd0, e.push_m});
          check("push_sel", {26'd0, sels}, (e.push_m != 0) ? 32'b000110 : 32'd0);
          check("push_b_mask", {25'd0, pb_m}, {25'd0, e.pb_m});
          check("nmi_clear_mask", {25'd0, clr_m}, {25'd0, e.clr_m});
        end
      end
      idx++;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_sync(input bit brk);
    sync = 1'b1; brk_op = brk;
    step(1);
    sync = 1'b0; brk_op = 1'b0;
  endtask

  task automatic raise_nmi();
    nmi_fall = 1'b1;
    step(1);
    nmi_fall = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    bit done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (!busy) begin done = 1'b1; break; end
      step(1);
    end
    if (!done) check({nm, "_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic wait_cycle(input logic [2:0] c);
    bit done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (busy && seq_cycle == c) begin done = 1'b1; break; end
      step(1);
    end
    if (!done) check("wait_cycle_timeout", 32'd1, 32'd0);
  endtask

  task automatic check_reset_state(input string nm);
    check({nm, "_busy"}, {31'd0, busy}, 32'd1);
    check({nm, "_seq_cycle"}, {29'd0, seq_cycle}, 32'd0);
    check({nm, "_vector_addr"}, {16'd0, vector_addr}, 32'h0000FFFC);
    check({nm, "_strobes"}, {26'd0, stack_push, push_b, vec_fetch_lo, vec_fetch_hi, set_i, nmi_clear}, 32'd0);
  endtask

  initial begin
    // Reset held, then the RESET sequence runs with ce=1.
    step(2);
    check_reset_state("reset");
    exp_q.push_back(mk(16'hFFFC, 1'b0, 1'b0, 1'b0));
    rst_n = 1'b1;
    wait_idle("reset_seq");
    check("post_reset_busy", {31'd0, busy}, 32'd0);
    check("post_reset_cycle", {29'd0, seq_cycle}, 32'd0);

    // NMI latched while idle, taken at the next sync.
    raise_nmi();
    step(2);
    check("nmi_wait_for_sync", {31'd0, busy}, 32'd0);
    exp_q.push_back(mk(16'hFFFA, 1'b1, 1'b0, 1'b1));
    pulse_sync(1'b0);
    wait_idle("nmi_seq");
    check("nmi_cleared", {31'd0, nmi_pending}, 32'd0);

    // IRQ masked by I, then taken; IRQ deasserted right after entry.
    irq_n = 1'b0; i_flag = 1'b1;
    pulse_sync(1'b0);
    step(2);
    check("irq_masked_idle", {31'd0, busy}, 32'd0);
    i_flag = 1'b0;
    exp_q.push_back(mk(16'hFFFE, 1'b1, 1'b0, 1'b0));
    pulse_sync(1'b0);
    irq_n = 1'b1;
    wait_idle("irq_seq");
    i_flag = 1'b1;

    // BRK: IRQ vector, B bit pushed only at cycle 4.
    exp_q.push_back(mk(16'hFFFE, 1'b1, 1'b1, 1'b0));
    pulse_sync(1'b1);
    wait_idle("brk_seq");

    // NMI and IRQ together: NMI wins; ce runs 1-of-3 through the sequence.
    raise_nmi();
    irq_n = 1'b0; i_flag = 1'b0;
    exp_q.push_back(mk(16'hFFFA, 1'b1, 1'b0, 1'b1));
    pulse_sync(1'b0);
    for (int k = 0; k < 90; k++) begin
      if (!busy) break;
      ce = (k % 3 == 2);
      step(1);
    end
    ce = 1'b1;
    check("slow_ce_done", {31'd0, busy}, 32'd0);
    check("nmi_over_irq_cleared", {31'd0, nmi_pending}, 32'd0);
    i_flag = 1'b1;
    pulse_sync(1'b0);
    step(1);
    check("irq_after_set_i_idle", {31'd0, busy}, 32'd0);
    irq_n = 1'b1;

    // NMI raised during an IRQ sequence at cycle 2.
    irq_n = 1'b0; i_flag = 1'b0;
`ifdef NMI_HIJACK_EN
    exp_q.push_back(mk(16'hFFFA, 1'b1, 1'b0, 1'b1));
`else
    exp_q.push_back(mk(16'hFFFE, 1'b1, 1'b0, 1'b0));
`endif
    pulse_sync(1'b0);
    irq_n = 1'b1; i_flag = 1'b1;
    wait_cycle(3'd2);
    raise_nmi();
    wait_idle("late_nmi_seq");
`ifdef NMI_HIJACK_EN
    check("late_nmi_pending", {31'd0, nmi_pending}, 32'd0);
`else
    check("late_nmi_pending", {31'd0, nmi_pending}, 32'd1);
    exp_q.push_back(mk(16'hFFFA, 1'b1, 1'b0, 1'b1));
    pulse_sync(1'b0);
    wait_idle("deferred_nmi_seq");
    check("deferred_nmi_cleared", {31'd0, nmi_pending}, 32'd0);
`endif

    // Reset mid-sequence aborts immediately to the reset state.
    irq_n = 1'b0; i_flag = 1'b0;
    pulse_sync(1'b0);
    irq_n = 1'b1; i_flag = 1'b1;
    wait_cycle(3'd3);
    rst_n = 1'b0;
    #1;
    check_reset_state("abort");
    exp_q.push_back(mk(16'hFFFC, 1'b0, 1'b0, 1'b0));
    step(1);
    rst_n = 1'b1;
    wait_idle("abort_reset_seq");

    step(3);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
